cc_miss_req_unit: RTL and testbench

- Upstream neighbour of the cache-controller line-fill stage.
- Accepts cache-miss requests from the hit/miss detection stage and issues one AXI read-address (AR) burst per miss to memory: 8 beats × 64 bits, WRAP burst, critical word first.
- Records each issued miss address in an internal first-word-fall-through (FWFT) miss-address FIFO. The fill stage reads that FIFO to deserialize the returning R-channel data into a 512-bit line.
- FIFO occupancy equals the number of outstanding line fills.

---
 rtl/cc_miss_req_unit.sv | 129 ++++++++++++
 tb/tb_cc_miss_req_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_req_unit.sv
// Miss request unit: one 8x64 WRAP AR burst per accepted miss, address queued FWFT for the fill stage.
// AR valid the cycle after accept; accept stalls while an AR is pending or the outstanding-miss FIFO is full.

module cc_miss_addr_fifo #(
  parameter int W         = 32,
  parameter int DEPTH_LG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop,
  output logic [W-1:0]         rdata,
  output logic                 empty,
  output logic                 full
);
  localparam logic [DEPTH_LG2:0] DEPTH = {1'b1, {DEPTH_LG2{1'b0}}};

  logic [W-1:0]         mem [0:(1<<DEPTH_LG2)-1];
  logic [DEPTH_LG2-1:0] wptr;
  logic [DEPTH_LG2-1:0] rptr;
  logic [DEPTH_LG2:0]   count;
  logic                 do_pop;

  // A pop against an empty FIFO is dropped, even when a push lands on the same edge.
  assign do_pop = pop & (count != '0);
  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign rdata  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module cc_miss_req_unit #(
  parameter int FIFO_DEPTH_LG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        mem_arready_i,
  input  logic        miss_addr_fifo_rden_i,
  output logic [31:0] miss_addr_fifo_rdata_o,
  output logic        miss_addr_fifo_empty_o,
  output logic        miss_addr_fifo_full_o
);
  typedef enum logic {IDLE, AR_REQ} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [31:0] line_addr;
  logic        addr_lsb_unused;

  assign line_addr       = {miss_req_addr_i[31:3], 3'b000};
  assign addr_lsb_unused = ^miss_req_addr_i[2:0];

  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'd3;
  assign mem_arburst_o = 2'b10;

  always_comb begin
    state_nxt        = state;
    miss_req_ready_o = 1'b0;
    mem_arvalid_o    = 1'b0;
    accept           = 1'b0;
    case (state)
      IDLE: begin
        miss_req_ready_o = !miss_addr_fifo_full_o && !rst;
        accept           = miss_req_valid_i && miss_req_ready_o;
        if (accept) state_nxt = AR_REQ;
      end
      AR_REQ: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset overrides a pending AR; the memory side never saw a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_araddr_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) mem_araddr_o <= line_addr;
    end
  end

  cc_miss_addr_fifo #(
    .W         (32),
    .DEPTH_LG2 (FIFO_DEPTH_LG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (line_addr),
    .pop       (miss_addr_fifo_rden_i),
    .rdata     (miss_addr_fifo_rdata_o),
    .empty     (miss_addr_fifo_empty_o),
    .full      (miss_addr_fifo_full_o)
  );
endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Bench for cc_miss_req_unit: directed scenarios plus random traffic against a queue-based model.
module tb_cc_miss_req_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic        ready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] rdata;
  logic        empty;
  logic        full;

  int total = 0;
  int bad = 0;

  // Model: queue of outstanding line addresses plus one pending AR.
  logic [31:0] mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_addr = '0;

  always #5 clk = ~clk;

  cc_miss_req_unit #(.FIFO_DEPTH_LG2(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_valid_i       (valid),
    .miss_req_addr_i        (addr),
    .miss_req_ready_o       (ready),
    .mem_arvalid_o          (arvalid),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .mem_arready_i          (arready),
    .miss_addr_fifo_rden_i  (rden),
    .miss_addr_fifo_rdata_o (rdata),
    .miss_addr_fifo_empty_o (empty),
    .miss_addr_fifo_full_o  (full)
  );

  function automatic bit exp_ready();
    return !rst && !m_pend && (mq.size() < 4);
  endfunction

  // Advance model with the current inputs, then cross one rising edge.
  task automatic tick();
    bit acc;
    bit pp;
    if (rst) begin
      mq.delete();
      m_pend = 1'b0;
      m_addr = '0;
    end else begin
      acc = valid && exp_ready();
      pp  = rden && (mq.size() != 0);
      if (m_pend && arready) m_pend = 1'b0;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        m_addr = addr & 32'hFFFF_FFF8;
        mq.push_back(m_addr);
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; valid = 1'b0; rden = 1'b0; arready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; addr = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
    total++; if (araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h want=0", araddr); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", ready); end
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    valid = 1'b1; addr = 32'h1234_567C; arready = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", ready); end
    tick();
    valid = 1'b0;
    @(negedge clk);
    total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid got=%b want=1", arvalid); end
    total++; if (araddr !== 32'h1234_5678) begin bad++; $display("FAIL single_araddr got=%h want=12345678", araddr); end
    total++; if ({arlen, arsize, arburst} !== {4'd7, 3'd3, 2'b10}) begin
      bad++; $display("FAIL single_ar_const got=%h/%h/%h want=7/3/2", arlen, arsize, arburst); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b want=0", empty); end
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL single_rdata got=%h want=12345678", rdata); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_ready_ar got=%b want=0", ready); end
    tick();
    @(negedge clk);
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_drop got=%b want=0", arvalid); end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_after_pop got=%b want=1", empty); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    arready = 1'b0; valid = 1'b1; addr = 32'h0000_1000;
    tick();
    addr = 32'h0000_200C;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) arready = 1'b1;
      @(negedge clk);
      total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_1000 || ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got arvalid=%b araddr=%h ready=%b want 1/00001000/0", i, arvalid, araddr, ready); end
      tick();
    end
    @(negedge clk);
    total++; if (arvalid !== 1'b0 || ready !== 1'b1) begin
      bad++; $display("FAIL bp_second_accept got arvalid=%b ready=%b want 0/1", arvalid, ready); end
    tick();
    valid = 1'b0;
    @(negedge clk);
    total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_2008) begin
      bad++; $display("FAIL bp_second_ar got arvalid=%b araddr=%h want 1/00002008", arvalid, araddr); end
    tick();
    rden = 1'b1;
    @(negedge clk);
    total++; if (rdata !== 32'h0000_1000) begin bad++; $display("FAIL bp_pop0 got=%h want=00001000", rdata); end
    tick();
    @(negedge clk);
    total++; if (rdata !== 32'h0000_2008) begin bad++; $display("FAIL bp_pop1 got=%h want=00002008", rdata); end
    tick();
    rden = 1'b0;
  endtask

  task automatic test_fill_full();
    logic [31:0] a [4];
    logic [31:0] order [4];
    a = '{32'h100, 32'h240, 32'h380, 32'h4C8};
    order = '{32'h240, 32'h380, 32'h4C8, 32'h5A0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; addr = a[i];
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL full_fill_ready[%0d] got=%b want=1", i, ready); end
      tick();
      valid = 1'b0;
      tick();
    end
    valid = 1'b1; addr = 32'h5A0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (full !== 1'b1 || ready !== 1'b0) begin
        bad++; $display("FAIL full_hold[%0d] got full=%b ready=%b want 1/0", i, full, ready); end
      tick();
    end
    rden = 1'b1;
    @(negedge clk);
    total++; if (rdata !== 32'h100) begin bad++; $display("FAIL full_pop_first got=%h want=00000100", rdata); end
    tick();
    rden = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL full_reopen got ready=%b full=%b want 1/0", ready, full); end
    tick();
    valid = 1'b0;
    @(negedge clk);
    total++; if (full !== 1'b1 || araddr !== 32'h5A0) begin
      bad++; $display("FAIL full_fifth got full=%b araddr=%h want 1/000005a0", full, araddr); end
    tick();
    rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (rdata !== order[i]) begin bad++; $display("FAIL full_order[%0d] got=%h want=%h", i, rdata, order[i]); end
      tick();
    end
    rden = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b want=1", empty); end
  endtask

  task automatic test_wrap_simul();
    logic [31:0] prev;
    logic [31:0] cur;
    apply_reset();
    prev = '0;
    for (int k = 0; k < 10; k++) begin
      cur = ($urandom & 32'hFFFF_FF00) | (k << 3);
      valid = 1'b1; addr = cur | ($urandom & 32'h7); rden = (k > 0);
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL wrap_ready[%0d] got=%b want=1", k, ready); end
      if (k > 0) begin
        total++; if (rdata !== prev) begin bad++; $display("FAIL wrap_pop[%0d] got=%h want=%h", k, rdata, prev); end
      end
      tick();
      valid = 1'b0; rden = 1'b0;
      @(negedge clk);
      total++; if (empty !== 1'b0 || full !== 1'b0 || rdata !== cur) begin
        bad++; $display("FAIL wrap_count1[%0d] got empty=%b full=%b rdata=%h want 0/0/%h", k, empty, full, rdata, cur); end
      tick();
      prev = cur;
    end
  endtask

  task automatic test_empty_pop();
    apply_reset();
    rden = 1'b1;
    tick();
    @(negedge clk);
    total++; if (empty !== 1'b1 || ready !== 1'b1) begin
      bad++; $display("FAIL epop_empty got empty=%b ready=%b want 1/1", empty, ready); end
    valid = 1'b1; addr = 32'hABCD_0011;
    tick();
    valid = 1'b0; rden = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b0 || rdata !== 32'hABCD_0010) begin
      bad++; $display("FAIL epop_pushpop got empty=%b rdata=%h want 0/abcd0010", empty, rdata); end
    tick();
    rden = 1'b1;
    tick();
    rden = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL epop_count1 got empty=%b want=1", empty); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    valid = 1'b1; addr = 32'h300;
    tick();
    valid = 1'b0;
    tick();
    arready = 1'b0; valid = 1'b1; addr = 32'h340;
    tick();
    valid = 1'b0;
    @(negedge clk);
    total++; if (arvalid !== 1'b1 || empty !== 1'b0) begin
      bad++; $display("FAIL rmid_pre got arvalid=%b empty=%b want 1/0", arvalid, empty); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; valid = 1'b1; addr = 32'h380;
    @(negedge clk);
    total++; if (arvalid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || ready !== 1'b1) begin
      bad++; $display("FAIL rmid_post got arvalid=%b empty=%b full=%b ready=%b want 0/1/0/1", arvalid, empty, full, ready); end
    valid = 1'b0; arready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 63) == 0);
      valid   = $urandom_range(0, 1);
      addr    = $urandom;
      arready = ($urandom_range(0, 2) != 0);
      rden    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      total++; if (ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, ready, exp_ready()); end
      total++; if (arvalid !== m_pend) begin bad++; $display("FAIL rnd_arvalid[%0d] got=%b want=%b", c, arvalid, m_pend); end
      total++; if (araddr !== m_addr) begin bad++; $display("FAIL rnd_araddr[%0d] got=%h want=%h", c, araddr, m_addr); end
      total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty[%0d] got=%b want=%b", c, empty, mq.size() == 0); end
      total++; if (full !== (mq.size() == 4)) begin bad++; $display("FAIL rnd_full[%0d] got=%b want=%b", c, full, mq.size() == 4); end
      if (mq.size() != 0) begin
        total++; if (rdata !== mq[0]) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", c, rdata, mq[0]); end
      end
      tick();
    end
    rst = 1'b0; valid = 1'b0; rden = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill_full();
    test_wrap_simul();
    test_empty_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
